// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, and FWFT or registered read output.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = 120,
    parameter int AE_THRESH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_T    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_T    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          wr_acc, rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // The wrap bit makes the pointer difference span 0..DEPTH, so occupancy
    // never needs a spare slot to tell full from empty.
    assign wr_ptr_nxt = wr_ptr + CW'(wr_acc);
    assign rd_ptr_nxt = rd_ptr + CW'(rd_acc);
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_T);
            almost_empty <= (count_nxt <= AE_T);
            // A fresh error in the clearing cycle keeps the flag set.
            overflow     <= (overflow  & ~clr_err) | (wr_en & full);
            underflow    <= (underflow & ~clr_err) | (rd_en & empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout = mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: an FWFT and a registered-output instance driven in
// lockstep, checked against a queue-based model plus table and corner sequences.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] din;

    logic [7:0] dout_a, dout_b;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [3:0] count_a, count_b;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_a),
        .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .count(count_a), .overflow(ovf_a), .underflow(udf_a), .clr_err(clr_err)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_b),
        .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .count(count_b), .overflow(ovf_b), .underflow(udf_b), .clr_err(clr_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, flags derived from its size.
    logic [7:0] q[$];
    bit         movf, mudf;
    logic [7:0] md0;

    typedef struct {
        bit         wr, rd;
        logic [7:0] din;
        int         cnt;
        bit         full, empty, af, ae, ovf, udf, hv;
        logic [7:0] head, dreg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit wr, bit rd, int d, int cnt, bit fl, bit em, bit af, bit ae,
                                bit ovf, bit udf, bit hv, int head, int dreg);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = 8'(d); v.cnt = cnt;
        v.full = fl; v.empty = em; v.af = af; v.ae = ae;
        v.ovf = ovf; v.udf = udf; v.hv = hv;
        v.head = 8'(head); v.dreg = 8'(dreg);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        movf = 1'b0;
        mudf = 1'b0;
        md0  = 8'h00;
    endtask

    task automatic model_edge(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit was_full, was_empty;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        if (r && !was_empty) md0 = q.pop_front();
        if (w && !was_full) q.push_back(d);
        movf = (movf & ~c) | (w & was_full);
        mudf = (mudf & ~c) | (r & was_empty);
    endtask

    task automatic compare_model();
        int n;
        n = q.size();
        chk("count_a", 32'(count_a), 32'(n));
        chk("count_b", 32'(count_b), 32'(n));
        chk("empty", 32'(empty_a), 32'(n == 0));
        chk("empty_b", 32'(empty_b), 32'(n == 0));
        chk("full", 32'(full_a), 32'(n == 8));
        chk("full_b", 32'(full_b), 32'(n == 8));
        chk("almost_full", 32'(af_a), 32'(n >= 6));
        chk("almost_empty", 32'(ae_a), 32'(n <= 1));
        chk("overflow", 32'(ovf_a), 32'(movf));
        chk("underflow", 32'(udf_a), 32'(mudf));
        chk("ovf_udf_b", 32'({ovf_b, udf_b, af_b, ae_b}), 32'({movf, mudf, n >= 6, n <= 1}));
        chk("dout_reg", 32'(dout_b), 32'(md0));
        if (n > 0) chk("dout_fwft", 32'(dout_a), 32'(q[0]));
    endtask

    task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
        wr_en = w; rd_en = r; clr_err = c; din = d;
        @(posedge clk);
        model_edge(w, r, c, d);
        #1;
        compare_model();
    endtask

    // Asserts reset between clock edges while inputs keep requesting writes.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        compare_model();
        @(posedge clk);
        #1;
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
        model_reset();

        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1, 0, 'h10 + k - 1, k, k == 8, 0, k >= 6, k <= 1, 0, 0, 1, 'h10, 0));
        tbl.push_back(mk(1, 0, 'hFF, 8, 1, 0, 1, 0, 1, 0, 1, 'h10, 0));
        for (int j = 1; j <= 8; j++)
            tbl.push_back(mk(0, 1, 0, 8 - j, 0, j == 8, (8 - j) >= 6, (8 - j) <= 1, 1, 0,
                             j < 8, 'h10 + j, 'h10 + j - 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 'h17));

        #12;
        chk("init_count", 32'(count_a), 32'd0);
        chk("init_flags", 32'({empty_a, full_a, ae_a, af_a, ovf_a, udf_a}), 32'b101000);
        chk("init_dout_reg", 32'(dout_b), 32'd0);
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].din);
            chk($sformatf("tbl%0d_count", i), 32'(count_a), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_flags", i), 32'({full_a, empty_a, af_a, ae_a, ovf_a, udf_a}),
                32'({tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].udf}));
            if (tbl[i].hv) chk($sformatf("tbl%0d_head", i), 32'(dout_a), 32'(tbl[i].head));
            chk($sformatf("tbl%0d_dreg", i), 32'(dout_b), 32'(tbl[i].dreg));
        end

        step(0, 0, 1, 8'h00);
        chk("clr_alone", 32'({ovf_a, udf_a}), 32'b00);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 8'(8'h20 + k));
        step(1, 0, 1, 8'hEE);
        chk("clr_vs_set_ovf", 32'(ovf_a), 32'd1);
        step(0, 0, 1, 8'h00);
        chk("clr_after_set", 32'(ovf_a), 32'd0);

        for (int k = 0; k < 5; k++) step(0, 1, 0, 8'h00);
        chk("pp_start_count", 32'(count_a), 32'd3);
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 8'(8'h40 + k));
            chk("pp_count", 32'(count_a), 32'd3);
        end
        for (int k = 0; k < 3; k++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h99);
        chk("empty_wr_rd_count", 32'(count_a), 32'd1);
        chk("empty_wr_rd_head", 32'(dout_a), 32'h99);

        for (int k = 0; k < 4; k++) step(1, 0, 0, 8'(8'h50 + k));
        chk("burst_count", 32'(count_a), 32'd5);
        async_reset();

        step(1, 0, 0, 8'h3C);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("post_rst_head", 32'(dout_a), 32'h3C);
        chk("reg_idle_zero", 32'(dout_b), 32'h00);
        step(0, 1, 0, 8'h00);
        chk("reg_read_3c", 32'(dout_b), 32'h3C);
        chk("reg_read_empty", 32'(empty_b), 32'd1);
        step(0, 0, 0, 8'h00);
        chk("reg_hold_3c", 32'(dout_b), 32'h3C);
        step(1, 0, 0, 8'hA5);
        step(0, 0, 0, 8'h00);
        chk("reg_no_read_a5", 32'(dout_b), 32'h3C);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("reg_hold_a5", 32'(dout_b), 32'hA5);

        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 1) ? 75 : 30;
            if (i == 300) async_reset();
            step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
                 $urandom_range(19) == 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
